// File: rtl/y_pattern_pkg.sv
// Shared types and constants for the Y-pattern encoder.
// Status codes, valid forward-function words, FIFO entry and FSM state.
package y_pattern_pkg;

  typedef enum logic [1:0] {
    ST_OK    = 2'b00,
    ST_AMBIG = 2'b01,
    ST_ERR   = 2'b10
  } status_t;

  localparam logic [3:0] W_000 = 4'b0001;
  localparam logic [3:0] W_011 = 4'b0010;
  localparam logic [3:0] W_101 = 4'b0100;
  localparam logic [3:0] W_111 = 4'b0011;
  localparam logic [3:0] W_AMB = 4'b0000;

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b10
  } state_t;

  typedef struct packed {
    logic [0:2] abc;
    status_t    status;
  } entry_t;

endpackage

// File: rtl/y_pattern_lut.sv
// Combinational inverse of the forward function: y1234_i -> abc_o/status_o.
// Ports: y1234_i (Y4..Y1), abc_o (a is bit 0), status_o (OK/AMBIG/ERR).
module y_pattern_lut
  import y_pattern_pkg::*;
(
  input  logic [3:0] y1234_i,
  output logic [0:2] abc_o,
  output status_t    status_o
);

  always_comb begin
    abc_o    = 3'b000;
    status_o = ST_ERR;
    unique case (1'b1)
      (y1234_i == W_000): begin
        abc_o    = 3'b000;
        status_o = ST_OK;
      end
      (y1234_i == W_011): begin
        abc_o    = 3'b011;
        status_o = ST_OK;
      end
      (y1234_i == W_101): begin
        abc_o    = 3'b101;
        status_o = ST_OK;
      end
      (y1234_i == W_111): begin
        abc_o    = 3'b111;
        status_o = ST_OK;
      end
      // Four inputs collapse onto 0000; no unique inverse exists.
      (y1234_i == W_AMB): begin
        abc_o    = 3'b000;
        status_o = ST_AMBIG;
      end
      default: begin
        abc_o    = 3'b000;
        status_o = ST_ERR;
      end
    endcase
  end

endmodule

// File: rtl/y_pattern_encoder.sv
// Decodes forward-function words into abc/status through a 2-entry FIFO.
// Ports: clk, rst_n, y1234/in_valid/in_ready, abc/status/out_valid/out_ready,
// err_cnt (only with Y_PATTERN_ENCODER_ERR_CNT_EN defined).
module y_pattern_encoder
  import y_pattern_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] y1234,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [0:2] abc,
  output logic [1:0] status,
  output logic       out_valid,
  input  logic       out_ready
`ifdef Y_PATTERN_ENCODER_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  logic [0:2] lut_abc;
  status_t    lut_st;

  y_pattern_lut u_lut (
    .y1234_i  (y1234),
    .abc_o    (lut_abc),
    .status_o (lut_st)
  );

  state_t state_q;
  entry_t mem_q [2];
  logic   wr_q;
  logic   rd_q;
  logic   in_ready_q;
  logic   out_valid_q;
  logic   push;
  logic   pop;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // Ready re-arms on the first edge out of reset.
      in_ready_q <= 1'b1;
      unique case (state_q)
        S_EMPTY: begin
          if (push) begin
            state_q     <= S_ONE;
            out_valid_q <= 1'b1;
          end
        end
        S_ONE: begin
          if (push && !pop) begin
            state_q    <= S_FULL;
            in_ready_q <= 1'b0;
          end else if (!push && pop) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        S_FULL: begin
          if (pop) begin
            state_q <= S_ONE;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= '{abc: lut_abc, status: lut_st};
        wr_q        <= ~wr_q;
      end
      if (pop) begin
        rd_q <= ~rd_q;
      end
    end
  end

`ifdef Y_PATTERN_ENCODER_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'h00;
    end else if (push && lut_st == ST_ERR && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign abc       = out_valid_q ? mem_q[rd_q].abc : 3'b000;
  assign status    = out_valid_q ? mem_q[rd_q].status : ST_OK;

endmodule

// File: doc/y_pattern_encoder.md
Y_PATTERN_ENCODER -- requirements
Module: y_pattern_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 y1234  input  [3:0]  forward-function output word; y1234[0]=Y1 ... y1234[3]=Y4.
REQ-005 in_valid  input  1  y1234 holds a word to accept.
REQ-006 in_ready  output  1  block accepts the word this cycle.
REQ-007 abc  output  [0:2]  recovered input; abc[0]=a (MSB), abc[2]=c.
REQ-008 status  output  [1:0]  result class: 00 OK, 01 AMBIG, 10 ERR.
REQ-009 out_valid  output  1  abc/status hold a result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 err_cnt  output  [7:0]  invalid-word count; present only per REQ-030.

Function
REQ-012 Word decode: 0001->abc 000 OK; 0010->011 OK; 0100->101 OK; 0011->111 OK.
REQ-013 Word 0000 SHALL produce abc 000, status AMBIG, because the forward function sends 001/010/100/110 to 0000.
REQ-014 Any other word (Y4 set, or any multi-hot word other than 0011) SHALL produce abc 000, status ERR.
REQ-015 A transfer occurs on a rising edge with in_valid&&in_ready; y1234 is sampled only then.
REQ-016 Results SHALL pass through a 2-entry FIFO; FSM states EMPTY, ONE, FULL.
REQ-017 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL; it is registered and never depends combinationally on out_ready.
REQ-018 out_valid SHALL be 1 in ONE and FULL; abc/status SHALL show the oldest entry.
REQ-019 Latency: a word accepted at edge N SHALL appear on abc/status with out_valid=1 after edge N if the FIFO was EMPTY.
REQ-020 Transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on simultaneous push and pop; FULL->ONE on pop; no push is possible in FULL.
REQ-021 While out_valid=1 and out_ready=0, abc/status SHALL hold stable.
REQ-022 Results leave in acceptance order; no result is dropped or duplicated.
REQ-023 Pointers SHALL be 1-bit and wrap 1->0.

Reset
REQ-024 Asserting rst_n low SHALL immediately force EMPTY, out_valid=0, in_ready=0, abc=000, status=00, and err_cnt=0, including mid-operation.
REQ-025 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-026 FIFO contents SHALL be discarded by reset and never emitted afterward.

Configuration
REQ-027 The macro Y_PATTERN_ENCODER_ERR_CNT_EN SHALL control the error counter.
REQ-028 With the macro defined, err_cnt SHALL increment by 1 on each accepted ERR word and saturate at 8'hFF; AMBIG words do not count.
REQ-029 With the macro defined, err_cnt SHALL be unaffected by out_ready or back-pressure.
REQ-030 With the macro undefined, the err_cnt port and the counter logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 The shared package y_pattern_pkg SHALL hold the status codes (ST_OK, ST_AMBIG, ST_ERR), the four valid word constants, and the FSM state type.
REQ-032 The REQ-012..014 map SHALL be a combinational sub-module y_pattern_lut (y1234 in, abc and status out), instantiated once.

Verification
REQ-033 Send 0001, 0010, 0100, 0011 with out_ready=1 -> abc 000, 011, 101, 111, all status 00, each one cycle after accept.
REQ-034 Send 0000, then 1000 -> abc 000/AMBIG, then abc 000/ERR; with the macro defined, err_cnt=1.
REQ-035 Hold out_ready=0 and push 0001 and 0010 -> in_ready=0 after the second accept and abc stays 000; raise out_ready -> 000 then 011 in order, and in_ready returns to 1.
REQ-036 In ONE state, assert push and pop on the same edge -> state stays ONE and the new result becomes the head next cycle.
REQ-037 With the macro defined, send 300 ERR words -> err_cnt saturates at 8'hFF.
REQ-038 Pull rst_n low with the FIFO FULL between edges -> out_valid and in_ready drop to 0 at once; after release, no stale result appears.
